// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter sharing one fixed-latency memory port between
// instruction fetch and data load/store requesters.
module mem_arbiter #(
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ready,
  output logic [15:0] if_data,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ready,
  output logic [15:0] d_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        if_stall,
  output logic        d_stall
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  localparam logic [3:0] LAST = 4'(LATENCY - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        gnt_d_q;
  logic        we_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] if_data_q;
  logic [15:0] d_rdata_q;
  logic        en_q;
  logic        wr_q;
  logic        if_rdy_q;
  logic        d_rdy_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      gnt_d_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      if_data_q <= '0;
      d_rdata_q <= '0;
      en_q      <= 1'b0;
      wr_q      <= 1'b0;
      if_rdy_q  <= 1'b0;
      d_rdy_q   <= 1'b0;
    end else begin
      if_rdy_q <= 1'b0;
      d_rdy_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // Data side wins ties so loads/stores never starve behind fetch.
          if (d_req) begin
            state_q <= ACCESS;
            cnt_q   <= '0;
            gnt_d_q <= 1'b1;
            we_q    <= d_we;
            addr_q  <= d_addr;
            wdata_q <= d_wdata;
            en_q    <= 1'b1;
            wr_q    <= d_we;
          end else if (if_req) begin
            state_q <= ACCESS;
            cnt_q   <= '0;
            gnt_d_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= if_addr;
            en_q    <= 1'b1;
            wr_q    <= 1'b0;
          end
        end
        ACCESS: begin
          if (cnt_q == LAST) begin
            state_q <= RESP;
            en_q    <= 1'b0;
            wr_q    <= 1'b0;
            if (gnt_d_q) begin
              d_rdy_q <= 1'b1;
              if (!we_q) d_rdata_q <= mem_rdata;
            end else begin
              if_rdy_q  <= 1'b1;
              if_data_q <= mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_en    = en_q;
  assign mem_wr    = wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_ready  = if_rdy_q;
  assign d_ready   = d_rdy_q;
  assign if_data   = if_data_q;
  assign d_rdata   = d_rdata_q;
  assign if_stall  = if_req & ~if_rdy_q;
  assign d_stall   = d_req & ~d_rdy_q;

endmodule
